ahb_slave_mem: RTL and testbench

AHB-Lite responder that terminates transfers driven by the AHB master/driver side of the bridge testbench. It decodes address/control in the address phase and stores or returns data in the data phase. It generates hreadyout wait states and two-cycle ERROR responses. The block serves as the reference slave model and as the bus front-end that the APB bridge will later replace.

---
 rtl/ahb_slave_mem.sv | 134 +++++++++++++
 tb/tb_ahb_slave_mem.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory responder: word storage with byte/halfword lanes,
// optional OKAY wait states and the two-cycle ERROR response.
module ahb_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [2:0]  hburst,
  input  logic [2:0]  hsize,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {st_idle, st_wait, st_err1, st_err2} state_t;

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic            live_q;
  logic            write_q;
  logic [AW-1:0]   idx_q;
  logic [3:0]      lanes_q;
  logic            hreadyout_q;
  logic [1:0]      hresp_q;
  logic [31:0]     mem [DEPTH];

  logic [32:0]     limit;
  logic [31:0]     offset;
  logic            addr_err;
  logic [3:0]      lanes;
  logic [AW-1:0]   idx;
  logic            accept;
  logic            commit;
  logic            unused;

  always_comb begin
    limit  = {1'b0, BASE_ADDR} + 33'(DEPTH * 4);
    offset = haddr - BASE_ADDR;
    idx    = offset[AW+1:2];
    addr_err = (haddr < BASE_ADDR) || ({1'b0, haddr} >= limit) || (hsize > 3'd2) ||
               ((hsize == 3'd1) && haddr[0]) || ((hsize == 3'd2) && (haddr[1:0] != 2'd0));
    lanes = 4'b1111;
    case (hsize)
      3'd0:    lanes = 4'b0001 << haddr[1:0];
      3'd1:    lanes = haddr[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
    // New address phases are only taken while the current data phase is completing.
    accept = hreadyin && ((state_q == st_idle) || (state_q == st_err2));
    commit = (state_q == st_idle) && live_q && write_q;
  end

  assign unused = ^{hburst, htrans[0], offset};

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= st_idle;
      cnt_q       <= 3'd0;
      live_q      <= 1'b0;
      write_q     <= 1'b0;
      idx_q       <= '0;
      lanes_q     <= 4'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 2'b00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else begin
      if (commit) begin
        for (int n = 0; n < 4; n++) begin
          if (lanes_q[n]) mem[idx_q][8*n +: 8] <= hwdata[8*n +: 8];
        end
      end
      unique case (state_q)
        st_idle, st_err2: begin
          if (accept) begin
            write_q <= hwrite;
            idx_q   <= idx;
            lanes_q <= lanes;
            if (htrans[1] && addr_err) begin
              live_q      <= 1'b0;
              state_q     <= st_err1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 2'b01;
            end else if (htrans[1] && (WAIT_STATES > 0)) begin
              live_q      <= 1'b1;
              state_q     <= st_wait;
              cnt_q       <= 3'(WAIT_STATES - 1);
              hreadyout_q <= 1'b0;
              hresp_q     <= 2'b00;
            end else begin
              live_q      <= htrans[1];
              state_q     <= st_idle;
              hreadyout_q <= 1'b1;
              hresp_q     <= 2'b00;
            end
          end else begin
            live_q      <= 1'b0;
            state_q     <= st_idle;
            hreadyout_q <= 1'b1;
            hresp_q     <= 2'b00;
          end
        end
        st_wait: begin
          if (cnt_q == 3'd0) begin
            state_q     <= st_idle;
            hreadyout_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        st_err1: begin
          state_q     <= st_err2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 2'b01;
        end
        default: state_q <= st_idle;
      endcase
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  // Read data appears only in the completing cycle of a valid, non-error read.
  assign hrdata    = ((state_q == st_idle) && live_q && !write_q) ? mem[idx_q] : 32'd0;

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: pipelined AHB master, expected read data
// queued at address acceptance and checked at data-phase completion.
module tb_ahb_slave_mem;

  logic        hclk = 1'b0;
  logic        hreset0, hreset2;
  logic [1:0]  htrans0, htrans2;
  logic        hwrite;
  logic [2:0]  hburst, hsize;
  logic [31:0] haddr, hwdata;
  logic        hreadyout0, hreadyout2;
  logic [1:0]  hresp0, hresp2;
  logic [31:0] hrdata0, hrdata2;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] sb[$];

  always #5 hclk = ~hclk;

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset0), .htrans(htrans0), .hwrite(hwrite), .hreadyin(hreadyout0),
    .hburst(hburst), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_slave_mem #(.BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hreset(hreset2), .htrans(htrans2), .hwrite(hwrite), .hreadyin(hreadyout2),
    .hburst(hburst), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hreadyout2), .hresp(hresp2), .hrdata(hrdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ready_of(input int d);
    return 32'(d == 2 ? hreadyout2 : hreadyout0);
  endfunction

  function automatic logic [31:0] resp_of(input int d);
    return 32'(d == 2 ? hresp2 : hresp0);
  endfunction

  function automatic logic [31:0] rdata_of(input int d);
    return d == 2 ? hrdata2 : hrdata0;
  endfunction

  task automatic set_tr(input int d, input logic [1:0] tr);
    htrans0 = (d == 2) ? 2'b00 : tr;
    htrans2 = (d == 2) ? tr : 2'b00;
  endtask

  task automatic add(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] wd, input logic err,
                     input logic [31:0] rd);
    beat_t b;
    b.tr = tr; b.wr = wr; b.sz = sz; b.a = a; b.wd = wd; b.err = err; b.rd = rd;
    beats.push_back(b);
  endtask

  // Runs the queued beats back-to-back on DUT d; entered and left at posedge+1.
  task automatic run_seq(input int d);
    beat_t       dp;
    int          i, k, w, guard;
    bit          have;
    logic [31:0] rdy, exp_rd;
    i = 0; k = 0; guard = 0; have = 0;
    dp = beats[0];
    while ((i < beats.size() || have) && guard < 100) begin
      guard++;
      if (i < beats.size()) begin
        set_tr(d, beats[i].tr);
        hwrite = beats[i].wr;
        hsize  = beats[i].sz;
        haddr  = beats[i].a;
      end else begin
        set_tr(d, 2'b00);
      end
      if (have) hwdata = dp.wd;
      rdy = ready_of(d);
      if (have) begin
        w = (dp.tr[1] && !dp.err) ? (d == 2 ? 2 : 0) : 0;
        if (dp.err) begin
          chk("err_ready", rdy, 32'(k >= 1));
          chk("err_resp", resp_of(d), 32'd1);
        end else begin
          chk("ok_ready", rdy, 32'(k >= w));
          chk("ok_resp", resp_of(d), 32'd0);
        end
        if (rdy[0]) begin
          exp_rd = sb.pop_front();
          chk("rdata", rdata_of(d), exp_rd);
        end else begin
          chk("wait_rdata", rdata_of(d), 32'd0);
        end
      end
      @(posedge hclk); #1;
      if (rdy[0]) begin
        if (i < beats.size()) begin
          dp = beats[i];
          sb.push_back(beats[i].rd);
          have = 1; i++; k = 0;
        end else begin
          have = 0;
        end
      end else begin
        k++;
      end
    end
    if (guard >= 100) chk("seq_timeout", 32'(guard), 32'd0);
    beats.delete();
  endtask

  initial begin
    hreset0 = 1'b1; hreset2 = 1'b1;
    htrans0 = 2'b00; htrans2 = 2'b00;
    hwrite = 1'b0; hburst = 3'b000; hsize = 3'd2; haddr = 32'd0; hwdata = 32'd0;
    #2;
    chk("rst_ready0", 32'(hreadyout0), 32'd1);
    chk("rst_resp0", 32'(hresp0), 32'd0);
    chk("rst_rdata0", hrdata0, 32'd0);
    chk("rst_ready2", 32'(hreadyout2), 32'd1);
    chk("rst_resp2", 32'(hresp2), 32'd0);
    @(posedge hclk); @(posedge hclk); #1;
    hreset0 = 1'b0; hreset2 = 1'b0;

    // Zero-wait write then back-to-back read of the same word.
    add(2'b10, 1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0004, 32'd0, 1'b0, 32'hDEAD_BEEF);
    run_seq(0);

    // Lane selection: replicated write data must only land in selected lanes.
    add(2'b10, 1'b1, 3'd0, 32'h8000_0009, 32'hAAAA_AAAA, 1'b0, 32'd0);
    add(2'b10, 1'b1, 3'd1, 32'h8000_000A, 32'h1234_1234, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0008, 32'd0, 1'b0, 32'h1234_AA00);
    run_seq(0);

    // Error cases, each followed through ERR2 by the next beat.
    add(2'b10, 1'b1, 3'd2, 32'h8000_0002, 32'hFFFF_FFFF, 1'b1, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0000, 32'd0, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0040, 32'd0, 1'b1, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h7FFF_FFFC, 32'd0, 1'b1, 32'd0);
    add(2'b10, 1'b1, 3'd1, 32'h8000_0005, 32'hFFFF_FFFF, 1'b1, 32'd0);
    add(2'b10, 1'b1, 3'd3, 32'h8000_0004, 32'hFFFF_FFFF, 1'b1, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0004, 32'd0, 1'b0, 32'hDEAD_BEEF);
    add(2'b10, 1'b1, 3'd2, 32'h8000_003C, 32'h0BAD_CAFE, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_003C, 32'd0, 1'b0, 32'h0BAD_CAFE);
    run_seq(0);

    // INCR4 burst with BUSY and IDLE beats carrying stray write data.
    hburst = 3'b011;
    add(2'b10, 1'b1, 3'd2, 32'h8000_0010, 32'h0000_0001, 1'b0, 32'd0);
    add(2'b01, 1'b1, 3'd2, 32'h8000_0020, 32'h0000_0BAD, 1'b0, 32'd0);
    add(2'b11, 1'b1, 3'd2, 32'h8000_0014, 32'h0000_0002, 1'b0, 32'd0);
    add(2'b00, 1'b1, 3'd2, 32'h8000_0024, 32'h0000_0BAD, 1'b0, 32'd0);
    add(2'b11, 1'b1, 3'd2, 32'h8000_0018, 32'h0000_0003, 1'b0, 32'd0);
    add(2'b11, 1'b1, 3'd2, 32'h8000_001C, 32'h0000_0004, 1'b0, 32'd0);
    run_seq(0);
    hburst = 3'b000;
    add(2'b10, 1'b0, 3'd2, 32'h8000_0010, 32'd0, 1'b0, 32'h0000_0001);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0014, 32'd0, 1'b0, 32'h0000_0002);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0018, 32'd0, 1'b0, 32'h0000_0003);
    add(2'b10, 1'b0, 3'd2, 32'h8000_001C, 32'd0, 1'b0, 32'h0000_0004);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0020, 32'd0, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0024, 32'd0, 1'b0, 32'd0);
    run_seq(0);

    // Two wait states on OKAY, still two cycles on ERROR.
    add(2'b10, 1'b1, 3'd2, 32'h8000_0000, 32'h55AA_55AA, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0000, 32'd0, 1'b0, 32'h55AA_55AA);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0040, 32'd0, 1'b1, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0000, 32'd0, 1'b0, 32'h55AA_55AA);
    run_seq(2);

    // Reset during the second wait cycle of a write aborts it.
    set_tr(2, 2'b10); hwrite = 1'b1; hsize = 3'd2; haddr = 32'h8000_000C;
    @(posedge hclk); #1;
    set_tr(2, 2'b00); hwdata = 32'hCAFE_F00D;
    chk("abort_wait1", 32'(hreadyout2), 32'd0);
    @(posedge hclk); #1;
    chk("abort_wait2", 32'(hreadyout2), 32'd0);
    #2 hreset2 = 1'b1;
    #1;
    chk("abort_ready", 32'(hreadyout2), 32'd1);
    chk("abort_resp", 32'(hresp2), 32'd0);
    @(posedge hclk); #1;
    hreset2 = 1'b0;
    add(2'b10, 1'b0, 3'd2, 32'h8000_000C, 32'd0, 1'b0, 32'd0);
    add(2'b10, 1'b0, 3'd2, 32'h8000_0000, 32'd0, 1'b0, 32'd0);
    run_seq(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
